// File: rtl/add_share_if.sv
// Requester-side bundle of the shared-adder arbiter: operand handshakes,
// pause control, tagged result strobe and busy status.
interface add_share_if #(
  parameter int NUM_REQ   = 4,
  parameter int DAT_WIDTH = 56,
  parameter int ID_WIDTH  = 2
);
  logic                           pause;
  logic [NUM_REQ-1:0]             req_valid;
  logic [NUM_REQ-1:0]             req_ready;
  logic [NUM_REQ*DAT_WIDTH-1:0]   req_a;
  logic [NUM_REQ*DAT_WIDTH-1:0]   req_b;
  logic                           res_valid;
  logic [ID_WIDTH-1:0]            res_id;
  logic [DAT_WIDTH:0]             res_sum;
  logic                           busy;

  // Requester / sequencer side
  modport master (
    output pause, req_valid, req_a, req_b,
    input  req_ready, res_valid, res_id, res_sum, busy
  );

  // Arbiter side
  modport slave (
    input  pause, req_valid, req_a, req_b,
    output req_ready, res_valid, res_id, res_sum, busy
  );
endinterface

// File: rtl/add_share_arbiter.sv
// Round-robin arbiter sharing one pipelined adder among NUM_REQ requesters.
// Grants one operand pair per cycle, registers it onto the adder inputs and
// carries the requester ID alongside the adder through a tag pipeline so each
// returning sum is tagged with its owner.
module add_share_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int DAT_WIDTH   = 56,
  parameter int ADD_LATENCY = 1,
  parameter int ID_WIDTH    = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  add_share_if.slave           bus,
  output logic [DAT_WIDTH-1:0] add_a,
  output logic [DAT_WIDTH-1:0] add_b,
  input  logic [DAT_WIDTH:0]   add_o
);

  logic [NUM_REQ-1:0]   grant;
  logic                 gnt_found;
  int                   gnt_idx;
  int                   scan_idx;

  logic [ID_WIDTH-1:0]  ptr_q, ptr_d;
  logic [DAT_WIDTH-1:0] add_a_q, add_a_d;
  logic [DAT_WIDTH-1:0] add_b_q, add_b_d;
  logic [ADD_LATENCY:0] tag_vld_q, tag_vld_d;
  logic [ID_WIDTH-1:0]  tag_id_q [ADD_LATENCY+1];
  logic [ID_WIDTH-1:0]  tag_id_d [ADD_LATENCY+1];
  logic                 res_valid_q, res_valid_d;
  logic [ID_WIDTH-1:0]  res_id_q, res_id_d;
  logic [DAT_WIDTH:0]   res_sum_q, res_sum_d;

  // Round-robin search: first valid requester starting at ptr, wrapping.
  // NOTE: every variable written here gets a default before any branch, so
  // no path leaves a value unassigned and no latch is inferred.
  always_comb begin
    grant     = '0;
    gnt_found = 1'b0;
    gnt_idx   = 0;
    scan_idx  = 0;
    if (!rst && !bus.pause) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        scan_idx = (int'(ptr_q) + k) % NUM_REQ;
        if (!gnt_found && bus.req_valid[scan_idx]) begin
          gnt_found       = 1'b1;
          gnt_idx         = scan_idx;
          grant[scan_idx] = 1'b1;
        end
      end
    end
  end

  // Next-state: operand capture, pointer advance, tag shift, result capture.
  always_comb begin
    ptr_d       = ptr_q;
    add_a_d     = add_a_q;
    add_b_d     = add_b_q;
    tag_vld_d   = {tag_vld_q[ADD_LATENCY-1:0], gnt_found};
    tag_id_d[0] = ID_WIDTH'(gnt_idx);
    for (int s = 1; s <= ADD_LATENCY; s++) begin
      tag_id_d[s] = tag_id_q[s-1];
    end
    res_valid_d = tag_vld_q[ADD_LATENCY];
    res_id_d    = res_id_q;
    res_sum_d   = res_sum_q;

    if (gnt_found) begin
      add_a_d = bus.req_a[gnt_idx*DAT_WIDTH +: DAT_WIDTH];
      add_b_d = bus.req_b[gnt_idx*DAT_WIDTH +: DAT_WIDTH];
      ptr_d   = (gnt_idx == NUM_REQ - 1) ? '0 : ID_WIDTH'(gnt_idx + 1);
    end

    if (tag_vld_q[ADD_LATENCY]) begin
      res_id_d  = tag_id_q[ADD_LATENCY];
      res_sum_d = add_o;
    end
  end

  // Control and datapath registers; reset discards everything in flight.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q       <= '0;
      add_a_q     <= '0;
      add_b_q     <= '0;
      tag_vld_q   <= '0;
      res_valid_q <= 1'b0;
      res_id_q    <= '0;
      res_sum_q   <= '0;
    end else begin
      ptr_q       <= ptr_d;
      add_a_q     <= add_a_d;
      add_b_q     <= add_b_d;
      tag_vld_q   <= tag_vld_d;
      res_valid_q <= res_valid_d;
      res_id_q    <= res_id_d;
      res_sum_q   <= res_sum_d;
    end
  end

  // Tag ID shift register.
  // NOTE: the IDs are never observed unless the matching valid bit is set,
  // so this storage is deliberately left without reset.
  always_ff @(posedge clk) begin
    for (int s = 0; s <= ADD_LATENCY; s++) begin
      tag_id_q[s] <= tag_id_d[s];
    end
  end

  assign bus.req_ready = grant;
  assign bus.res_valid = res_valid_q;
  assign bus.res_id    = res_id_q;
  assign bus.res_sum   = res_sum_q;
  assign bus.busy      = |tag_vld_q;
  assign add_a         = add_a_q;
  assign add_b         = add_b_q;

endmodule

// File: tb/tb_add_share_arbiter.sv
// Self-checking bench for add_share_arbiter: a pipelined adder model sits on
// the adder port, a reference arbiter model predicts grants and pushes expected
// results into a scoreboard, and an independent monitor pops and compares.
module tb_add_share_arbiter;
  localparam int N  = 4;
  localparam int DW = 56;
  localparam int L  = 1;
  localparam int IW = 2;

  typedef struct {
    int             due;
    logic [IW-1:0]  id;
    logic [DW:0]    sum;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] add_a, add_b;
  logic [DW:0]   add_o;
  logic [DW:0]   adder_pipe [L];

  int            cyc = 0;
  int            n_tests = 0;
  int            n_fail = 0;
  bit            mon_en = 1'b0;
  exp_t          sb [$];

  int            mptr = 0;
  logic [DW-1:0] exp_add_a = '0;
  logic [DW-1:0] exp_add_b = '0;

  add_share_if #(.NUM_REQ(N), .DAT_WIDTH(DW), .ID_WIDTH(IW)) bus ();

  add_share_arbiter #(
    .NUM_REQ(N), .DAT_WIDTH(DW), .ADD_LATENCY(L), .ID_WIDTH(IW)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus.slave),
    .add_a (add_a),
    .add_b (add_b),
    .add_o (add_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural adder with L register stages.
  always @(posedge clk) begin
    adder_pipe[0] <= {1'b0, add_a} + {1'b0, add_b};
    for (int s = 1; s < L; s++) adder_pipe[s] <= adder_pipe[s-1];
  end
  assign add_o = adder_pipe[L-1];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] rnd_op();
    logic [63:0] r;
    r = {$urandom, $urandom};
    return r[DW-1:0];
  endfunction

  task automatic set_op(input int i, input logic [DW-1:0] a, input logic [DW-1:0] b);
    bus.req_a[i*DW +: DW] = a;
    bus.req_b[i*DW +: DW] = b;
  endtask

  task automatic rand_ops();
    for (int i = 0; i < N; i++) set_op(i, rnd_op(), rnd_op());
  endtask

  // Reference model for one cycle: predict grant and busy, then update state.
  task automatic step();
    logic [N-1:0]  exp_rdy;
    logic          found;
    logic          bexp;
    int            gid;
    int            idx;
    logic [DW-1:0] a, b;
    @(negedge clk);
    #1;
    exp_rdy = '0;
    found   = 1'b0;
    gid     = 0;
    if (!rst && !bus.pause) begin
      for (int k = 0; k < N; k++) begin
        idx = (mptr + k) % N;
        if (!found && bus.req_valid[idx]) begin
          found = 1'b1;
          gid   = idx;
        end
      end
    end
    if (found) exp_rdy[gid] = 1'b1;
    bexp = 1'b0;
    foreach (sb[j]) if (sb[j].due - L - 1 <= cyc) bexp = 1'b1;

    check("req_ready", 64'(bus.req_ready), 64'(exp_rdy));
    check("busy", 64'(bus.busy), 64'(bexp));
    check("add_a", 64'(add_a), 64'(exp_add_a));
    check("add_b", 64'(add_b), 64'(exp_add_b));

    if (rst) begin
      sb.delete();
      mptr      = 0;
      exp_add_a = '0;
      exp_add_b = '0;
    end else if (found) begin
      a = bus.req_a[gid*DW +: DW];
      b = bus.req_b[gid*DW +: DW];
      sb.push_back('{due: cyc + L + 2, id: IW'(gid), sum: {1'b0, a} + {1'b0, b}});
      mptr      = (gid + 1) % N;
      exp_add_a = a;
      exp_add_b = b;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Monitor: a result is required exactly when the scoreboard head is due.
  always @(negedge clk) begin
    if (mon_en) begin
      if (sb.size() > 0 && sb[0].due == cyc) begin
        check("res_valid", 64'(bus.res_valid), 64'd1);
        if (bus.res_valid) begin
          check("res_id", 64'(bus.res_id), 64'(sb[0].id));
          check("res_sum", 64'(bus.res_sum), 64'(sb[0].sum));
        end
        void'(sb.pop_front());
      end else begin
        check("res_valid_idle", 64'(bus.res_valid), 64'd0);
      end
    end
  end

  initial begin
    bus.pause     = 1'b0;
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    rst           = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst    = 1'b0;
    mon_en = 1'b1;

    // Reset then idle: everything stays zero.
    for (int i = 0; i < 10; i++) begin
      step();
      check("idle_res_sum", 64'(bus.res_sum), 64'd0);
      check("idle_res_id", 64'(bus.res_id), 64'd0);
    end

    // Single op from requester 2 with a carry out of the top bit.
    set_op(2, {DW{1'b1}}, DW'(1));
    bus.req_valid = 4'b0100;
    step();
    bus.req_valid = '0;
    steps(6);

    // All requesters continuously valid for 8 cycles from ptr = 0.
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.req_valid = '1;
    for (int i = 0; i < 8; i++) begin
      rand_ops();
      step();
    end
    bus.req_valid = '0;
    steps(4);

    // Round-robin resume: grant 1, then only 0 and 3 valid -> 3 then 0.
    rand_ops();
    bus.req_valid = 4'b0010;
    step();
    bus.req_valid = 4'b1001;
    steps(2);
    bus.req_valid = '0;
    steps(4);

    // Pause with valids held high.
    rand_ops();
    bus.req_valid = '1;
    steps(3);
    bus.pause = 1'b1;
    steps(4);
    bus.pause = 1'b0;
    steps(2);
    bus.req_valid = '0;
    steps(4);

    // Reset mid-flight discards in-flight ops and clears the pointer.
    rand_ops();
    bus.req_valid = 4'b0110;
    steps(2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.req_valid = 4'b0110;
    step();
    bus.req_valid = '0;
    steps(5);

    // Randomised traffic with occasional pause and reset.
    for (int i = 0; i < 300; i++) begin
      rand_ops();
      bus.req_valid = N'($urandom);
      bus.pause     = ($urandom_range(0, 7) == 0);
      rst           = ($urandom_range(0, 49) == 0);
      step();
    end
    rst           = 1'b0;
    bus.pause     = 1'b0;
    bus.req_valid = '0;
    steps(L + 4);

    check("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Hard time limit so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/add_share_arbiter.md
# add_share_arbiter

Round-robin arbiter and sequencer sharing one pipelined wide adder (carry-select or plain `+`, fixed latency) among NUM_REQ requesters. It accepts at most one operand pair per cycle over valid/ready handshakes and registers the pair onto the adder inputs. It tracks the requester ID of every in-flight operation through a tag pipeline matched to the adder latency, and returns each sum tagged with its requester ID. It sits between the requesting datapaths and the adder instance, which is instantiated alongside it by the parent.

## Interface
- NUM_REQ, 4, number of requesters (2..16)
- DAT_WIDTH, 56, operand width; matches adder BLOCK_SIZE*NUM_BLOCKS
- ADD_LATENCY, 1, clock cycles from add_a/add_b to add_o at the adder (1..8)
- ID_WIDTH, 2, requester ID width; must satisfy 2^ID_WIDTH >= NUM_REQ

- clk  in  1  sole clock, rising edge
- rst  in  1  synchronous, active-high reset
- pause  in  1  when high, no new grants; in-flight operations still complete
- req_valid  in  NUM_REQ  per-requester operand valid
- req_ready  out  NUM_REQ  per-requester grant; one-hot or zero
- req_a  in  NUM_REQ*DAT_WIDTH  operand A, requester i at bits [i*DAT_WIDTH +: DAT_WIDTH]
- req_b  in  NUM_REQ*DAT_WIDTH  operand B, same packing
- add_a  out  DAT_WIDTH  registered operand A to adder
- add_b  out  DAT_WIDTH  registered operand B to adder
- add_o  in  DAT_WIDTH+1  adder sum, ADD_LATENCY cycles after add_a/add_b
- res_valid  out  1  result strobe, single cycle per operation
- res_id  out  ID_WIDTH  requester ID of result
- res_sum  out  DAT_WIDTH+1  registered sum including carry-out
- busy  out  1  high while any operation is issued or in flight

## Operation
- Round-robin pointer ptr (ID_WIDTH bits) is reset to 0.
- Each cycle with pause=0, req_ready[i] is high for exactly one i: the first i with req_valid[i]=1, searching ptr, ptr+1, … mod NUM_REQ. No valid means all zero. pause=1 or rst=1 forces all zero.
- req_ready is combinational from req_valid, ptr, pause and rst. Requesters must not make req_valid depend on req_ready.
- Transfer occurs when req_valid[i] && req_ready[i]. On transfer:
  - add_a/add_b <= req_a/req_b slice i.
  - Issue tag {valid=1, id=i} enters stage 0 of the tag pipeline.
  - ptr <= (i+1) mod NUM_REQ.
- With no transfer: ptr holds, add_a/add_b hold their values, and a tag of valid=0 enters the pipeline.
- Tag pipeline is ADD_LATENCY+1 stages deep: stage 0 is aligned with add_a/add_b, and the last stage is aligned with the registered result.
- Result register samples add_o when the tag at stage ADD_LATENCY is valid. res_valid and res_id take that tag. res_sum holds its last value when no result is sampled.
- Sum width is DAT_WIDTH+1; the carry-out is in the MSB. No overflow is possible.
- busy = OR of all tag-stage valid bits.
- Fairness: a continuously asserted requester is granted within NUM_REQ transfers.
- Reset:
  - Clears ptr, all tag valids, res_valid, res_id, res_sum, add_a and add_b.
  - Reset mid-operation discards in-flight operations; no result is emitted for them.

## Timing
- Reset values: req_ready=0, add_a=0, add_b=0, res_valid=0, res_id=0, res_sum=0, busy=0.
- Transfer at edge T: add_a/add_b are valid after T, and res_valid is high for the cycle after edge T+ADD_LATENCY+1.
- Total latency from handshake to result is ADD_LATENCY+2 edges (3 at defaults).
- Throughput is one operation per cycle, with no bubbles between back-to-back transfers from any mix of requesters.
- Results return in issue order; there is no result back-pressure, and downstream must accept every res_valid.
- pause asserted in cycle C blocks the grant in cycle C. Operations already issued emit on schedule.
- rst asserted at the same edge as a transfer: the reset wins, no operation is issued, and ptr=0.

## Test plan
- Reset then idle: all outputs 0 for 10 cycles; busy=0, res_valid=0.
- Single op: requester 2 with a=0xFFFFFFFFFFFFFF, b=1, handshake at cycle 5.
  - Required: res_valid=1 in cycle 8 with res_id=2 and res_sum=0x100000000000000; res_valid=0 in cycles 9-12.
- All four requesters valid continuously for 8 cycles.
  - Required: grants in order 0,1,2,3,0,1,2,3 and one result per cycle.
  - Each result sum equals that requester's a+b with the matching res_id.
- Round-robin resume: grant to 1, then only requesters 0 and 3 valid.
  - Required: the next grant is 3, then 0.
- Pause: 3 ops issued back-to-back, then pause=1 for 4 cycles while valids stay high.
  - Required: 3 results emitted, no grants during pause, busy drops after the last result, and grants resume the cycle pause=0.
- Reset mid-flight: issue 2 ops, then assert rst one cycle later.
  - Required: no res_valid afterward, ptr=0, and the next grant goes to the lowest valid index.
